// File: rtl/char_ram_writer.sv
// char_ram_writer
// Converts an ASCII/control byte stream into write cycles for the 1024-entry
// character RAM. Tracks a row/column cursor, and blanks the whole RAM after
// reset and on form feed (0x0C).
// Optional feature: define CHAR_WR_HEX_EN so that byte 0x01 prints the
// following byte as two upper-case hex digits.

module char_ram_writer #(
  parameter int         COLS  = 48,
  parameter int         ROWS  = 16,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] ram_Adr,
  output logic [7:0] ram_Data,
  output logic       write_Ram,
  output logic       busy
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [9:0] LAST_ADR = 10'd1023;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_DEL = 8'h7F;
`ifdef CHAR_WR_HEX_EN
  localparam logic [7:0] CH_HEX = 8'h01;
`endif

`ifdef CHAR_WR_HEX_EN
  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_IDLE    = 2'd1,
    S_HEX_ARG = 2'd2,
    S_HEX_LO  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1
  } state_t;
`endif

  state_t     state;
  state_t     next_state;

  logic [5:0] col;
  logic [3:0] row;
  logic [5:0] col_nxt;
  logic [3:0] row_nxt;
  logic [9:0] clr_cnt;
  logic       clr_done;

  logic       accept;
  logic       is_print;
  logic [5:0] adv_col;
  logic [3:0] adv_row;
  logic [3:0] row_inc;
  logic [5:0] col_dec;

  logic       wr_req;
  logic [9:0] wr_adr;
  logic [7:0] wr_data;

`ifdef CHAR_WR_HEX_EN
  logic [3:0] hex_lo;

  function automatic logic [7:0] hex_digit(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    return 8'h37 + {4'h0, nib};
  endfunction
`endif

  assign accept   = in_valid && in_ready;
  assign clr_done = (state == S_CLEAR) && (clr_cnt == LAST_ADR);

  // Printable is 0x20..0x7E plus the whole upper half; DEL is just a control byte.
  assign is_print = (in_data >= 8'h20) && (in_data != CH_DEL);

  // Cursor arithmetic shared by every path that advances or steps back.
  always_comb begin
    row_inc = (row == LAST_ROW) ? 4'd0 : row + 4'd1;
    adv_col = (col == LAST_COL) ? 6'd0 : col + 6'd1;
    adv_row = (col == LAST_COL) ? row_inc : row;
    col_dec = col - 6'd1;
  end

  // FSM state register; reset always lands in CLEAR so the screen is blanked.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_CLEAR;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_CLEAR: begin
        if (clr_done) next_state = S_IDLE;
      end
      S_IDLE: begin
        if (accept) begin
          if (in_data == CH_FF) begin
            next_state = S_CLEAR;
          end
`ifdef CHAR_WR_HEX_EN
          else if (in_data == CH_HEX) begin
            next_state = S_HEX_ARG;
          end
`endif
        end
      end
`ifdef CHAR_WR_HEX_EN
      S_HEX_ARG: begin
        if (accept) next_state = S_HEX_LO;
      end
      S_HEX_LO: begin
        next_state = S_IDLE;
      end
`endif
      default: next_state = S_CLEAR;
    endcase
  end

  // FSM outputs: bytes are only taken in states that are waiting for one.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:    in_ready = 1'b1;
`ifdef CHAR_WR_HEX_EN
      S_HEX_ARG: in_ready = 1'b1;
`endif
      default:   in_ready = 1'b0;
    endcase
  end

  // Next cursor position for the current state and accepted byte.
  always_comb begin
    col_nxt = col;
    row_nxt = row;
    case (state)
      S_CLEAR: begin
        if (clr_done) begin
          col_nxt = 6'd0;
          row_nxt = 4'd0;
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (is_print) begin
            col_nxt = adv_col;
            row_nxt = adv_row;
          end else if (in_data == CH_CR) begin
            col_nxt = 6'd0;
          end else if (in_data == CH_LF) begin
            col_nxt = 6'd0;
            row_nxt = row_inc;
          end else if ((in_data == CH_BS) && (col != 6'd0)) begin
            col_nxt = col_dec;
          end
        end
      end
`ifdef CHAR_WR_HEX_EN
      S_HEX_ARG: begin
        if (accept) begin
          col_nxt = adv_col;
          row_nxt = adv_row;
        end
      end
      S_HEX_LO: begin
        col_nxt = adv_col;
        row_nxt = adv_row;
      end
`endif
      default: begin
        col_nxt = col;
        row_nxt = row;
      end
    endcase
  end

  // Write request for this cycle; it is registered onto the RAM port below.
  always_comb begin
    wr_req  = 1'b0;
    wr_adr  = {row, col};
    wr_data = in_data;
    case (state)
      S_CLEAR: begin
        wr_req  = 1'b1;
        wr_adr  = clr_cnt;
        wr_data = BLANK;
      end
      S_IDLE: begin
        if (accept) begin
          if (is_print) begin
            wr_req = 1'b1;
          end else if ((in_data == CH_BS) && (col != 6'd0)) begin
            wr_req  = 1'b1;
            wr_adr  = {row, col_dec};
            wr_data = BLANK;
          end
        end
      end
`ifdef CHAR_WR_HEX_EN
      S_HEX_ARG: begin
        if (accept) begin
          wr_req  = 1'b1;
          wr_data = hex_digit(in_data[7:4]);
        end
      end
      S_HEX_LO: begin
        wr_req  = 1'b1;
        wr_data = hex_digit(hex_lo);
      end
`endif
      default: begin
        wr_req = 1'b0;
      end
    endcase
  end

  // Cursor register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= 6'd0;
      row <= 4'd0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // Clear address counter; wraps back to 0 on its own after the last blank write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt <= 10'd0;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_cnt + 10'd1;
    end else if ((state == S_IDLE) && accept && (in_data == CH_FF)) begin
      clr_cnt <= 10'd0;
    end
  end

`ifdef CHAR_WR_HEX_EN
  // Low nibble is held for the second digit printed one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_lo <= 4'd0;
    end else if ((state == S_HEX_ARG) && accept) begin
      hex_lo <= in_data[3:0];
    end
  end
`endif

  // Registered RAM write port; the strobe is a single-cycle pulse per write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_Adr   <= 10'd0;
      ram_Data  <= 8'd0;
      write_Ram <= 1'b0;
    end else begin
      write_Ram <= wr_req;
      if (wr_req) begin
        ram_Adr  <= wr_adr;
        ram_Data <= wr_data;
      end
    end
  end

  // Busy follows the state we are entering, so it drops with the final clear write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (next_state == S_CLEAR);
    end
  end

endmodule

// File: tb/tb_char_ram_writer.sv
// tb_char_ram_writer
// Self-checking bench for char_ram_writer: reset/clear behaviour, a table of
// single-byte vectors, cursor-wrap and backspace corner cases, reset during a
// clear, the optional hex command (CHAR_WR_HEX_EN), and random traffic
// compared against a screen-level reference model.

`timescale 1ns/1ps

module tb_char_ram_writer;

  localparam int         COLS  = 48;
  localparam int         ROWS  = 16;
  localparam logic [7:0] BLANK = 8'h20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] ram_Adr;
  logic [7:0] ram_Data;
  logic       write_Ram;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [9:0] adr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  typedef struct {
    logic [7:0] din;
    logic       exp_wr;
    logic [9:0] exp_adr;
    logic [7:0] exp_data;
  } vec_t;

  wr_t obs_q[$];
  wr_t exp_q[$];

  int m_row = 0;
  int m_col = 0;
`ifdef CHAR_WR_HEX_EN
  bit m_hex_pending = 1'b0;
`endif
  string hex_chars = "0123456789ABCDEF";

  char_ram_writer #(
    .COLS (COLS),
    .ROWS (ROWS),
    .BLANK(BLANK)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ram_Adr  (ram_Adr),
    .ram_Data (ram_Data),
    .write_Ram(write_Ram),
    .busy     (busy)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every RAM write away from the active edge.
  always @(negedge clk) begin
    if (reset_n && write_Ram) begin
      obs_q.push_back('{ram_Adr, ram_Data, cyc});
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: screen rules expressed on plain integers.
  function automatic void push_exp(input int adr, input logic [7:0] data);
    wr_t w;
    w.adr  = 10'(adr);
    w.data = data;
    w.cyc  = 0;
    exp_q.push_back(w);
  endfunction

  function automatic void model_put(input logic [7:0] ch);
    push_exp(m_row * 64 + m_col, ch);
    m_col++;
    if (m_col == COLS) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < 1024; a++) push_exp(a, BLANK);
    m_row = 0;
    m_col = 0;
`ifdef CHAR_WR_HEX_EN
    m_hex_pending = 1'b0;
`endif
  endfunction

  function automatic void model_byte(input logic [7:0] b);
`ifdef CHAR_WR_HEX_EN
    if (m_hex_pending) begin
      model_put(hex_chars[b[7:4]]);
      model_put(hex_chars[b[3:0]]);
      m_hex_pending = 1'b0;
      return;
    end
    if (b == 8'h01) begin
      m_hex_pending = 1'b1;
      return;
    end
`endif
    if (b >= 8'h20 && b != 8'h7F) begin
      model_put(b);
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      m_row = (m_row + 1) % ROWS;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_exp(m_row * 64 + m_col, BLANK);
      end
    end else if (b == 8'h0C) begin
      model_clear();
    end
  endfunction

  // Send one byte; called in the low clock phase, returns at the negedge after
  // acceptance so the resulting write (if any) is visible on return.
  task automatic apply_stimulus(input logic [7:0] b);
    int waited = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && waited < 1200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_output("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_byte(b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic goto_cursor(input int r, input int c);
    apply_stimulus(8'h0D);
    while (m_row != r) apply_stimulus(8'h0A);
    while (m_col != c) apply_stimulus(8'h78);
  endtask

  task automatic check_write(input string name, input logic [9:0] adr, input logic [7:0] data);
    check_output({name, "_strobe"}, write_Ram, 1);
    check_output({name, "_adr"}, ram_Adr, adr);
    check_output({name, "_data"}, ram_Data, data);
  endtask

  // Waits for the write to address 1023, checking handshake flags on the way.
  task automatic wait_clear_done(input string name);
    int n = 0;
    int flag_errs = 0;
    bit seen = 1'b0;
    int sz;
    while (n < 1200) begin
      @(negedge clk);
      n++;
      if (write_Ram && ram_Adr == 10'd1023) begin
        seen = 1'b1;
        break;
      end
      if (in_ready || !busy) flag_errs++;
    end
    check_output({name, "_reached_1023"}, seen, 1);
    check_output({name, "_flags_during"}, flag_errs, 0);
    check_output({name, "_ready_at_end"}, in_ready, 1);
    check_output({name, "_busy_at_end"}, busy, 0);
    @(negedge clk);
    check_output({name, "_strobe_ends"}, write_Ram, 0);
    sz = obs_q.size();
    if (sz >= 1024) check_output({name, "_consecutive"}, obs_q[sz-1].cyc - obs_q[sz-1024].cyc, 1023);
    else check_output({name, "_write_count"}, sz, 1024);
  endtask

  task automatic compare_queues(input string name);
    int n;
    repeat (3) @(negedge clk);
    check_output({name, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_output({name, "_write"}, {obs_q[i].adr, obs_q[i].data}, {exp_q[i].adr, exp_q[i].data});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[13];
    logic [7:0] ctl[7];
    int found;

    vecs[0]  = '{8'h48, 1'b1, 10'h000, 8'h48};
    vecs[1]  = '{8'h69, 1'b1, 10'h001, 8'h69};
    vecs[2]  = '{8'h0D, 1'b0, 10'h000, 8'h00};
    vecs[3]  = '{8'h0A, 1'b0, 10'h000, 8'h00};
    vecs[4]  = '{8'h41, 1'b1, 10'h040, 8'h41};
    vecs[5]  = '{8'h08, 1'b1, 10'h040, 8'h20};
    vecs[6]  = '{8'h08, 1'b0, 10'h000, 8'h00};
    vecs[7]  = '{8'h07, 1'b0, 10'h000, 8'h00};
    vecs[8]  = '{8'h80, 1'b1, 10'h040, 8'h80};
    vecs[9]  = '{8'h7E, 1'b1, 10'h041, 8'h7E};
    vecs[10] = '{8'h20, 1'b1, 10'h042, 8'h20};
    vecs[11] = '{8'hFF, 1'b1, 10'h043, 8'hFF};
    vecs[12] = '{8'h1F, 1'b0, 10'h000, 8'h00};
    ctl = '{8'h0D, 8'h0A, 8'h08, 8'h01, 8'h07, 8'h00, 8'h1B};

    // Reset values, then the power-up clear.
    repeat (3) @(negedge clk);
    check_output("rst_in_ready", in_ready, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_adr", ram_Adr, 0);
    check_output("rst_data", ram_Data, 0);
    check_output("rst_strobe", write_Ram, 0);
    model_clear();
    reset_n = 1'b1;
    @(negedge clk);
    check_write("clr_first", 10'h000, BLANK);
    check_output("clr_first_busy", busy, 1);
    check_output("clr_first_ready", in_ready, 0);
    wait_clear_done("power_clear");
    compare_queues("power_clear");

    // Single-byte vector table from cursor (0,0).
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].din);
      check_output($sformatf("vec%0d_strobe", i), write_Ram, vecs[i].exp_wr);
      if (vecs[i].exp_wr) begin
        check_output($sformatf("vec%0d_adr", i), ram_Adr, vecs[i].exp_adr);
        check_output($sformatf("vec%0d_data", i), ram_Data, vecs[i].exp_data);
      end
    end
    repeat (2) @(negedge clk);
    if (obs_q.size() >= 2) check_output("hi_back_to_back", obs_q[1].cyc - obs_q[0].cyc, 1);
    else check_output("hi_write_count", obs_q.size(), 2);
    compare_queues("table");

    // Form feed clear.
    apply_stimulus(8'h0C);
    check_output("ff_busy", busy, 1);
    check_output("ff_ready", in_ready, 0);
    wait_clear_done("ff_clear");
    compare_queues("ff_clear");

    // Last-cell wrap, CR+LF, and backspace corners.
    goto_cursor(15, 47);
    apply_stimulus(8'h5A);
    check_write("wrap_last", 10'h3EF, 8'h5A);
    apply_stimulus(8'h51);
    check_write("wrap_first", 10'h000, 8'h51);
    goto_cursor(3, 5);
    apply_stimulus(8'h0D);
    apply_stimulus(8'h0A);
    apply_stimulus(8'h41);
    check_write("crlf", 10'h100, 8'h41);
    goto_cursor(2, 7);
    apply_stimulus(8'h08);
    check_write("bs_mid", 10'h086, BLANK);
    apply_stimulus(8'h0D);
    apply_stimulus(8'h08);
    check_output("bs_col0_strobe", write_Ram, 0);
`ifndef CHAR_WR_HEX_EN
    apply_stimulus(8'h01);
    check_output("ctl01_strobe", write_Ram, 0);
    apply_stimulus(8'h6B);
    check_write("after_ctl01", 10'h080, 8'h6B);
`endif
    compare_queues("corners");

    // Reset in the middle of a clear restarts it from address 0.
    apply_stimulus(8'h0C);
    found = 0;
    for (int n = 0; n < 1200 && found == 0; n++) begin
      @(negedge clk);
      if (write_Ram && ram_Adr == 10'd500) found = 1;
    end
    check_output("reach_500", found, 1);
    reset_n = 1'b0;
    #1;
    check_output("midrst_strobe", write_Ram, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_ready", in_ready, 0);
    check_output("midrst_adr", ram_Adr, 0);
    obs_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    @(negedge clk);
    check_write("midrst_first", 10'h000, BLANK);
    wait_clear_done("midrst_clear");
    compare_queues("midrst_clear");

`ifdef CHAR_WR_HEX_EN
    // Hex command from cursor (0,0); FF inside the argument is data.
    apply_stimulus(8'h01);
    check_output("hex_cmd_strobe", write_Ram, 0);
    apply_stimulus(8'h3C);
    check_write("hex_hi", 10'h000, 8'h33);
    check_output("hex_lo_ready", in_ready, 0);
    @(negedge clk);
    check_write("hex_lo", 10'h001, 8'h43);
    check_output("hex_back_ready", in_ready, 1);
    apply_stimulus(8'h01);
    apply_stimulus(8'h0C);
    check_write("hex_ff_hi", 10'h002, 8'h30);
    check_output("hex_ff_busy", busy, 0);
    compare_queues("hex");
`endif

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 1) b = 8'h0C;
      else if (r < 25) b = ctl[$urandom_range(0, 6)];
      else if (r < 70) b = 8'($urandom_range(8'h20, 8'h7E));
      else b = 8'($urandom_range(8'h80, 8'hFF));
      apply_stimulus(b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (1100) begin
      if (in_ready) break;
      @(negedge clk);
    end
    compare_queues("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_ram_writer.md
# char_ram_writer

Front-end text writer for the character display. It accepts a byte stream of ASCII characters and control codes over a valid/ready handshake. It maintains a row/column cursor and generates write cycles (address, data, strobe) into the 1024-entry character RAM read by the character-display pixel stage. It also blanks the screen after reset and on a clear-screen command.

## Interface
- `COLS`, default 48: visible columns per row (legal 1..64); cursor column wraps at `COLS`.
- `ROWS`, default 16: rows (legal 1..16); cursor row wraps at `ROWS`.
- `BLANK`, default 8'h20: fill character used by clear and backspace.
- `clk`  in  1: system clock; also used as the character RAM write clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_data`  in  8: input byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block accepts a byte this cycle.
- `ram_Adr`  out  10: character RAM write address, `{row[3:0], col[5:0]}`.
- `ram_Data`  out  8: character RAM write data.
- `write_Ram`  out  1: write strobe, one cycle per write.
- `busy`  out  1: high while a clear sequence is running.

## Operation
- A byte is accepted when `in_valid && in_ready` are both high at a rising edge of `clk`.
- States: CLEAR, IDLE, HEX_ARG, HEX_LO. HEX_ARG and HEX_LO exist only with the hex feature (see Configuration).
- **CLEAR**
  - Clear counter runs 0..1023; each cycle writes `BLANK` to that address.
  - After address 1023: cursor is set to (0,0) and the state moves to IDLE.
  - `in_ready` is 0 and `busy` is 1 throughout.
- **IDLE**, `in_ready` = 1, action per accepted byte:
  - 0x20..0x7E, or any byte ≥0x80: write the byte at the cursor, then advance the cursor.
  - Cursor advance: `col+1`. If `col == COLS-1`, col goes to 0 and row goes to row+1. If `row == ROWS-1`, row goes to 0 (no scrolling).
  - 0x0D (CR): col goes to 0; no write.
  - 0x0A (LF): col goes to 0 and row goes to row+1, with wrap; no write.
  - 0x08 (BS): if `col > 0`, col goes to col-1 and `BLANK` is written at the new position. At col 0 it is a no-op.
  - 0x0C (FF): enter CLEAR; counter restarts at 0.
  - Any other byte < 0x20: ignored and consumed.
- Row/column arithmetic is unsigned: col is 6 bits, row is 4 bits. Unused address bits are driven from the zero-extended cursor.
- **Reset** (asserted at any time, including mid-clear):
  - All outputs go to 0, cursor to (0,0), clear counter to 0.
  - The state goes to CLEAR and a full 1024-write clear runs from address 0.

## Timing
- `ram_Adr`, `ram_Data` and `write_Ram` are registered. A write appears the cycle after the byte is accepted, and `write_Ram` is high for exactly 1 cycle per write.
- Throughput is one printable byte per cycle in IDLE.
- Clear timing:
  - The first clear write is on the first edge after `reset_n` deasserts, or the cycle after FF is accepted.
  - The clear is 1024 consecutive strobes.
  - `in_ready` returns high in the cycle after the write to 1023.
- During CLEAR, `in_valid` is ignored and no byte is consumed.
- Reset values: `in_ready`=0, `busy`=0, `ram_Adr`=0, `ram_Data`=0, `write_Ram`=0. After reset deasserts, `busy` is 1 from the first edge.

## Configuration
- `CHAR_WR_HEX_EN` defined: byte 0x01 in IDLE is consumed and the state moves to HEX_ARG.
  - HEX_ARG (`in_ready`=1): the next accepted byte writes the ASCII hex digit of its high nibble ('0'-'9', 'A'-'F'), advances the cursor, latches the low nibble and moves to HEX_LO.
  - HEX_LO (`in_ready`=0 for one cycle): writes the low-nibble digit, advances the cursor and returns to IDLE.
  - FF received in HEX_ARG is treated as data, not as a command.
- `CHAR_WR_HEX_EN` undefined: 0x01 is an ignored control byte, and the HEX states are absent.

## Test plan
- Reset release → 1024 strobes, addresses 0..1023, data 0x20; `in_ready` goes high the cycle after address 1023; `busy` falls at the same time.
- After clear, send 'H','i' back-to-back → writes (0x000,0x48) and (0x001,0x69) on consecutive cycles.
- Cursor at col 47 row 15, send 'Z' → write to 0x3EF; the next 'Q' writes to 0x000. Also: CR then LF from (5,3) → the next 'A' writes to 0x100.
- At (7,2), send BS → write (0x086,0x20). At col 0, send BS → no strobe.
- Send FF, then pulse `reset_n` low at clear address 500 → the clear restarts at 0 and runs the full 1024 writes.
- With `CHAR_WR_HEX_EN` at cursor (0,0): send 0x01, 0x3C → writes (0x000,0x33) and (0x001,0x43); `in_ready` is low for one cycle.
